layer4_window_reader: RTL and testbench

//   Consumer end of the layer-4 row delay line: accepts a raster-order pixel stream, keeps two
//   row delays (window regs + (IMG_W-3)-deep shift FIFO per row), emits a 3x3 sliding window.

---
 rtl/layer4_window_reader.sv | 159 +++++++++++++++
 tb/tb_layer4_window_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer4_window_reader.sv
// Layer-4 row delay line consumer: turns a raster pixel stream into
// 3x3 sliding windows (valid padding) for the conv PE array.
module layer4_window_reader #(
    parameter int DATA_W = 128,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       win_valid,
    output logic [9*DATA_W-1:0]        win_data,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FD = IMG_W - 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   w0_q [3];
    logic [DATA_W-1:0]   w1_q [3];
    logic [DATA_W-1:0]   w2_q [3];
    logic [DATA_W-1:0]   w0_d [3];
    logic [DATA_W-1:0]   w1_d [3];
    logic [DATA_W-1:0]   w2_d [3];
    logic [DATA_W-1:0]   f1_q [FD];
    logic [DATA_W-1:0]   f2_q [FD];
    logic [DATA_W-1:0]   f1_d [FD];
    logic [DATA_W-1:0]   f2_d [FD];
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                win_valid_q, win_valid_d;
    logic [9*DATA_W-1:0] win_data_q, win_data_d;
    logic [RW-1:0]       win_row_q, win_row_d;
    logic [CW-1:0]       win_col_q, win_col_d;
    logic                accept;
    logic                last_col;
    logic                last_px;

    always_comb begin
        state_d     = state_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        f1_d        = f1_q;
        f2_d        = f2_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = 1'b0;
        win_data_d  = win_data_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        accept      = in_valid && (state_q == RUN);
        last_col    = (col_q == CW'(IMG_W - 1));
        last_px     = last_col && (row_q == RW'(IMG_H - 1));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (accept && last_px) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            // Each row: 3 window regs then FD-deep FIFO, IMG_W accepts total
            w2_d[0] = w2_q[1];
            w2_d[1] = w2_q[2];
            w2_d[2] = in_data;
            f2_d[0] = w2_q[0];
            for (int i = 1; i < FD; i++) f2_d[i] = f2_q[i-1];
            w1_d[0] = w1_q[1];
            w1_d[1] = w1_q[2];
            w1_d[2] = f2_q[FD-1];
            f1_d[0] = w1_q[0];
            for (int i = 1; i < FD; i++) f1_d[i] = f1_q[i-1];
            w0_d[0] = w0_q[1];
            w0_d[1] = w0_q[2];
            w0_d[2] = f1_q[FD-1];

            if (last_col) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                win_valid_d = 1'b1;
                win_row_d   = row_q - RW'(2);
                win_col_d   = col_q - CW'(2);
                for (int c = 0; c < 3; c++) begin
                    win_data_d[c*DATA_W +: DATA_W]     = w0_d[c];
                    win_data_d[(3+c)*DATA_W +: DATA_W] = w1_d[c];
                    win_data_d[(6+c)*DATA_W +: DATA_W] = w2_d[c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < 3; i++) begin
                w0_q[i] <= '0;
                w1_q[i] <= '0;
                w2_q[i] <= '0;
            end
            for (int i = 0; i < FD; i++) begin
                f1_q[i] <= '0;
                f2_q[i] <= '0;
            end
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            f1_q        <= f1_d;
            f2_q        <= f2_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign frame_done = (state_q == DONE);
    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

endmodule

// File: tb/tb_layer4_window_reader.sv
// Bench for layer4_window_reader: scoreboard of expected windows built
// from the frame pixel array, checked against each output cycle.
module tb_layer4_window_reader;

    localparam int DW = 128;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NP = W * H;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            win_valid;
    logic [9*DW-1:0] win_data;
    logic [2:0]      win_row;
    logic [2:0]      win_col;
    logic            busy;
    logic            frame_done;

    typedef struct {
        logic [9*DW-1:0] d;
        int              r;
        int              c;
    } win_t;

    win_t            q[$];
    logic [DW-1:0]   pix [NP];
    int              checks = 0;
    int              errors = 0;
    int              nwin = 0;
    int              ndone = 0;
    int              idx = 0;
    bit              pend_win = 0;
    bit              pend_done = 0;
    logic [9*DW-1:0] last_d = '0;
    int              last_r = -1;
    int              last_c = -1;

    layer4_window_reader #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_valid(win_valid), .win_data(win_data),
        .win_row(win_row), .win_col(win_col),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen(input int salt);
        for (int i = 0; i < NP; i++) begin
            pix[i] = '0;
            if (salt != 0)
                pix[i] = {$urandom, $urandom, $urandom, 32'h0};
            pix[i][15:0] = 16'(i);
        end
    endtask

    task automatic do_start();
        nwin  = 0;
        ndone = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send(input int gap, input int stop_n, input int poke_run);
        int n = 0;
        int cyc = 0;
        while (n < stop_n && cyc < 5000) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 99) >= gap);
            in_data  = pix[n];
            start    = (n == poke_run);
            @(negedge clk);
            if (in_valid && in_ready) n++;
            cyc++;
        end
        chk("send_count", n, stop_n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        chk({tag, "_nwin"}, nwin, 36);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_qempty"}, q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_last_row"}, last_r, 5);
        chk({tag, "_last_col"}, last_c, 5);
    endtask

    // Output monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            pend_win  = 0;
            pend_done = 0;
            idx       = 0;
        end else begin
            chk("win_valid", win_valid, pend_win);
            chk("frame_done", frame_done, pend_done);
            if (win_valid) nwin++;
            if (frame_done) ndone++;
            if (win_valid && q.size() > 0) begin
                win_t e;
                e = q.pop_front();
                chk("win_row", win_row, e.r);
                chk("win_col", win_col, e.c);
                for (int s = 0; s < 9; s++)
                    chk($sformatf("win_data[%0d]", s),
                        win_data[s*DW +: DW], e.d[s*DW +: DW]);
                last_d = win_data;
                last_r = int'(win_row);
                last_c = int'(win_col);
            end
            pend_win  = 0;
            pend_done = 0;
            if (in_valid && in_ready) begin
                int r;
                int c;
                r = idx / W;
                c = idx % W;
                if (r >= 2 && c >= 2) begin
                    win_t e;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.d[(3*i+j)*DW +: DW] = pix[(r-2+i)*W + (c-2+j)];
                    e.r = r - 2;
                    e.c = c - 2;
                    q.push_back(e);
                    pend_win = 1;
                end
                if (idx == NP - 1) begin
                    pend_done = 1;
                    idx = 0;
                end else begin
                    idx++;
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        gen(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_data_lo", win_data[DW-1:0], 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Plain frame, pixel = row*8+col
        do_start();
        @(negedge clk);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 1);
        send(0, NP, -1);
        end_frame("f1");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk($sformatf("f1_last_slice%0d", 3*i+j),
                    last_d[(3*i+j)*DW +: DW], DW'((5+i)*8 + 5+j));

        // Random stalls
        gen(1);
        do_start();
        send(40, NP, -1);
        end_frame("f2");

        // Abort after pixel 30
        gen(2);
        do_start();
        send(0, 31, -1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_win_valid", win_valid, 0);
        chk("abort_win_data_hi", win_data[9*DW-1 -: DW], 0);
        chk("abort_win_row", win_row, 0);
        chk("abort_win_col", win_col, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        gen(0);
        do_start();
        send(0, NP, -1);
        end_frame("f3");

        // Start pulsed in RUN, then in DONE
        gen(4);
        do_start();
        send(30, NP, 20);
        chk("done_state", frame_done, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", busy, 0);
        end_frame("f4");

        // Back-to-back frame
        gen(5);
        do_start();
        send(10, NP, -1);
        end_frame("f5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
